// File: rtl/dep_issue_scheduler.sv
// Dependency-matrix issue scheduler: tracks per-slot producer dependencies,
// clears columns on completion and issues ready slots round-robin over valid/ready.
module dep_issue_scheduler #(
  parameter int unsigned bs = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [$clog2(bs)-1:0] alloc_index,
  input  logic [bs-1:0]         idt,
  input  logic                  complete_valid,
  input  logic [$clog2(bs)-1:0] complete_index,
  input  logic                  issue_ready,
  output logic                  issue_valid,
  output logic [$clog2(bs)-1:0] issue_index,
  output logic [$clog2(bs):0]   occupancy,
  output logic                  full,
  output logic                  empty,
  output logic                  alloc_err
);
  localparam int unsigned iw = $clog2(bs);
  localparam int unsigned ow = iw + 1;

  logic [bs-1:0] valid_q, valid_d;
  logic [bs-1:0] issued_q, issued_d;
  logic [bs-1:0] dep_q [bs];
  logic [bs-1:0] dep_d [bs];
  logic [iw-1:0] rr_q, rr_d;
  logic          err_d;
  logic [bs-1:0] ready;
  logic [bs-1:0] self_mask;
  logic [iw-1:0] cand;
  logic [ow-1:0] occ;

  // A slot is ready once allocated, not yet issued, and all producers done
  always_comb begin
    for (int unsigned i = 0; i < bs; i++) begin
      ready[i] = valid_q[i] & ~issued_q[i] & ~(|dep_q[i]);
    end
  end

  // Round-robin pick: first ready slot at or after rr_q, wrapping; idle offer holds rr_q
  always_comb begin
    issue_valid = 1'b0;
    issue_index = rr_q;
    cand        = '0;
    for (int unsigned k = 0; k < bs; k++) begin
      cand = rr_q + iw'(k);
      if (!issue_valid && ready[cand]) begin
        issue_valid = 1'b1;
        issue_index = cand;
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int unsigned i = 0; i < bs; i++) begin
      occ = occ + ow'(valid_q[i]);
    end
  end

  assign occupancy = occ;
  assign full      = (occ == ow'(bs));
  assign empty     = (occ == '0);

  // Next state: completion, then allocation (masked by post-completion valid), then issue
  always_comb begin
    valid_d   = valid_q;
    issued_d  = issued_q;
    dep_d     = dep_q;
    rr_d      = rr_q;
    err_d     = 1'b0;
    self_mask = '0;
    self_mask[alloc_index] = 1'b1;

    if (complete_valid && valid_q[complete_index] && issued_q[complete_index]) begin
      valid_d[complete_index]  = 1'b0;
      issued_d[complete_index] = 1'b0;
      for (int unsigned k = 0; k < bs; k++) begin
        dep_d[k][complete_index] = 1'b0;
      end
    end

    if (alloc_valid) begin
      if (valid_d[alloc_index]) begin
        err_d = 1'b1;
      end else begin
        dep_d[alloc_index]    = idt & valid_d & ~self_mask;
        valid_d[alloc_index]  = 1'b1;
        issued_d[alloc_index] = 1'b0;
      end
    end

    if (issue_valid && issue_ready) begin
      issued_d[issue_index] = 1'b1;
      rr_d                  = issue_index + iw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      issued_q  <= '0;
      rr_q      <= '0;
      alloc_err <= 1'b0;
      for (int unsigned k = 0; k < bs; k++) begin
        dep_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      issued_q  <= issued_d;
      rr_q      <= rr_d;
      alloc_err <= err_d;
      for (int unsigned k = 0; k < bs; k++) begin
        dep_q[k] <= dep_d[k];
      end
    end
  end

endmodule

// File: tb/tb_dep_issue_scheduler.sv
// Testbench for dep_issue_scheduler: directed scenarios plus random traffic,
// scored against a slot-level reference model through an expectation queue.
module tb_dep_issue_scheduler;
  localparam int BS = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [IW-1:0] alloc_index;
  logic [BS-1:0] idt;
  logic          complete_valid;
  logic [IW-1:0] complete_index;
  logic          issue_ready;
  logic          issue_valid;
  logic [IW-1:0] issue_index;
  logic [IW:0]   occupancy;
  logic          full;
  logic          empty;
  logic          alloc_err;

  dep_issue_scheduler #(.bs(BS)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_index(alloc_index), .idt(idt),
    .complete_valid(complete_valid), .complete_index(complete_index),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_index(issue_index),
    .occupancy(occupancy), .full(full), .empty(empty), .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit iv;
    int ii;
    int occ;
    bit full;
    bit empty;
    bit err;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: which slots hold instructions, which went out, who waits on whom
  bit            m_valid [BS];
  bit            m_issued[BS];
  bit [BS-1:0]   m_dep   [BS];
  int            m_rr;
  bit            m_err;
  bit            m_known = 1'b0;

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_pick(output bit v, output int idx);
    v   = 1'b0;
    idx = m_rr;
    for (int k = 0; k < BS; k++) begin
      int s;
      s = (m_rr + k) % BS;
      if (!v && m_valid[s] && !m_issued[s] && m_dep[s] == '0) begin
        v   = 1'b1;
        idx = s;
      end
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    int   n;
    n = 0;
    for (int k = 0; k < BS; k++) n += int'(m_valid[k]);
    model_pick(e.iv, e.ii);
    e.occ   = n;
    e.full  = (n == BS);
    e.empty = (n == 0);
    e.err   = m_err;
    expq.push_back(e);
  endfunction

  function automatic void model_update(bit r, bit av, int ai, bit [BS-1:0] id,
                                       bit cv, int ci, bit ir);
    bit pv;
    int pi;
    if (r) begin
      for (int k = 0; k < BS; k++) begin
        m_valid[k] = 0; m_issued[k] = 0; m_dep[k] = '0;
      end
      m_rr = 0; m_err = 0;
      return;
    end
    model_pick(pv, pi);
    m_err = 0;
    if (cv && m_valid[ci] && m_issued[ci]) begin
      m_valid[ci] = 0; m_issued[ci] = 0;
      for (int k = 0; k < BS; k++) m_dep[k][ci] = 1'b0;
    end
    if (av) begin
      if (m_valid[ai]) m_err = 1;
      else begin
        m_dep[ai] = '0;
        for (int j = 0; j < BS; j++)
          if (id[j] && m_valid[j] && j != ai) m_dep[ai][j] = 1'b1;
        m_valid[ai] = 1; m_issued[ai] = 0;
      end
    end
    if (pv && ir) begin
      m_issued[pi] = 1;
      m_rr = (pi + 1) % BS;
    end
  endfunction

  // One clock: record expectation for the current state, drive inputs, advance model
  task automatic step(input bit r, input bit av, input int ai, input logic [BS-1:0] id,
                      input bit cv, input int ci, input bit ir);
    if (m_known) push_expected();
    rst            = r;
    alloc_valid    = av;
    alloc_index    = IW'(ai);
    idt            = id;
    complete_valid = cv;
    complete_index = IW'(ci);
    issue_ready    = ir;
    model_update(r, av, ai, id, cv, ci, ir);
    if (r) m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ir);
    step(0, 0, 0, '0, 0, 0, ir);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("mon_issue_valid", int'(issue_valid), int'(e.iv));
      check("mon_issue_index", int'(issue_index), e.ii);
      check("mon_occupancy",   int'(occupancy),   e.occ);
      check("mon_full",        int'(full),        int'(e.full));
      check("mon_empty",       int'(empty),       int'(e.empty));
      check("mon_alloc_err",   int'(alloc_err),   int'(e.err));
    end
  end

  initial begin
    int free_q[$];
    int iss_q[$];
    int ai, ci;
    bit av, cv, ir, r;
    logic [BS-1:0] id;

    rst = 1'b1; alloc_valid = 0; alloc_index = '0; idt = '0;
    complete_valid = 0; complete_index = '0; issue_ready = 0;
    @(posedge clk); #1;

    // Reset with every other input active
    step(1, 1, 3, '1, 1, 3, 1);
    check("rst_issue_valid", int'(issue_valid), 0);
    check("rst_occupancy", int'(occupancy), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_alloc_err", int'(alloc_err), 0);

    // Independent issue
    step(0, 1, 3, '0, 0, 0, 0);
    check("ind_valid", int'(issue_valid), 1);
    check("ind_index", int'(issue_index), 3);
    idle(1);
    check("ind_after_valid", int'(issue_valid), 0);
    check("ind_rr_ptr", int'(issue_index), 4);

    // RAW chain
    do_reset();
    step(0, 1, 0, 16'h0000, 0, 0, 0);
    step(0, 1, 1, 16'h0001, 0, 0, 0);
    check("raw_first_index", int'(issue_index), 0);
    idle(1);
    check("raw_blocked", int'(issue_valid), 0);
    idle(1);
    check("raw_still_blocked", int'(issue_valid), 0);
    step(0, 0, 0, '0, 1, 0, 0);
    check("raw_wake_valid", int'(issue_valid), 1);
    check("raw_wake_index", int'(issue_index), 1);

    // Stale idt bits for free slots are discarded
    do_reset();
    step(0, 1, 4, 16'h0000, 0, 0, 0);
    step(0, 1, 5, 16'h0050, 0, 0, 0);
    check("stale_first", int'(issue_index), 4);
    idle(1);
    check("stale_waits", int'(issue_valid), 0);
    step(0, 0, 0, '0, 1, 4, 0);
    check("stale_wake_valid", int'(issue_valid), 1);
    check("stale_wake_index", int'(issue_index), 5);

    // Round robin from rr_ptr=7 over slots 2, 6, 9
    do_reset();
    step(0, 1, 6, 16'h0000, 0, 0, 0);
    idle(1);
    step(0, 1, 6, 16'h0040, 1, 6, 0);
    step(0, 1, 2, 16'h0000, 0, 0, 0);
    step(0, 1, 9, 16'h0000, 0, 0, 0);
    check("rr_first", int'(issue_index), 9);
    idle(1);
    check("rr_second", int'(issue_index), 2);
    idle(1);
    check("rr_third", int'(issue_index), 6);
    idle(1);
    check("rr_done", int'(issue_valid), 0);

    // Complete and reallocate the same slot, then a dropped allocation
    do_reset();
    step(0, 1, 7, 16'h0000, 0, 0, 0);
    idle(1);
    step(0, 1, 7, 16'h0080, 1, 7, 0);
    check("same_slot_valid", int'(issue_valid), 1);
    check("same_slot_index", int'(issue_index), 7);
    check("same_slot_no_err", int'(alloc_err), 0);
    check("same_slot_occ", int'(occupancy), 1);
    step(0, 1, 2, 16'h0000, 0, 0, 0);
    step(0, 1, 2, 16'h0080, 0, 0, 0);
    check("drop_err", int'(alloc_err), 1);
    check("drop_dep_kept", int'(issue_index), 2);
    check("drop_occ", int'(occupancy), 2);
    idle(0);
    check("drop_err_pulse", int'(alloc_err), 0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      free_q.delete();
      iss_q.delete();
      for (int k = 0; k < BS; k++) begin
        if (!m_valid[k]) free_q.push_back(k);
        if (m_valid[k] && m_issued[k]) iss_q.push_back(k);
      end
      r  = ($urandom_range(0, 299) == 0);
      av = ($urandom_range(0, 1) == 1);
      ai = (free_q.size() > 0 && $urandom_range(0, 4) != 0) ?
           free_q[$urandom_range(0, free_q.size() - 1)] : int'($urandom_range(0, BS - 1));
      cv = ($urandom_range(0, 1) == 1);
      ci = (iss_q.size() > 0 && $urandom_range(0, 3) != 0) ?
           iss_q[$urandom_range(0, iss_q.size() - 1)] : int'($urandom_range(0, BS - 1));
      id = BS'($urandom() & $urandom() & $urandom());
      ir = ($urandom_range(0, 3) != 0);
      step(r, av, ai, id, cv, ci, ir);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
